window_extract: RTL

- Parametrised successor to the fixed 5x5 frame extractor.
- Copies a WIN_H x WIN_W window from the cell grid into a registered frame buffer, one cell per clock.
- The window origin is signed, so pieces may sit partly above or left of the grid.
- Sits between the playfield grid register and the piece collision/render logic; uses a start/busy/done handshake.

---
 rtl/window_extract.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/window_extract.sv
// Copies a WIN_H x WIN_W window at a signed origin out of the cell grid into a registered frame.
// Define WINDOW_EXTRACT_ROW_MODE_EN to fetch a whole window row per clock instead of one cell.
module window_extract #(
    parameter int GRID_ROWS = 22,
    parameter int GRID_COLS = 10,
    parameter int CELL_W    = 3,
    parameter int WIN_H     = 5,
    parameter int WIN_W     = 5,
    parameter logic [CELL_W-1:0] FILL_VAL = '0,
    parameter int ORG_W     = 6
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [GRID_ROWS*GRID_COLS*CELL_W-1:0]   c_grid,
    input  logic signed [ORG_W-1:0]                 row_org,
    input  logic signed [ORG_W-1:0]                 col_org,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic [WIN_H*WIN_W*CELL_W-1:0]           c_frame,
    output logic                                    oob,
    output logic [$clog2(WIN_H*WIN_W+1)-1:0]        occ_cnt
);

    localparam int NCELL = WIN_H * WIN_W;
    localparam int CNT_W = $clog2(NCELL + 1);
    localparam int IW    = (WIN_H > 1) ? $clog2(WIN_H) : 1;
    localparam int JW    = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int RW    = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int CIW   = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam logic signed [ORG_W:0] ROWS_S = (ORG_W+1)'(GRID_ROWS);
    localparam logic signed [ORG_W:0] COLS_S = (ORG_W+1)'(GRID_COLS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                                   state_q;
    logic [IW-1:0]                            i_q;
`ifndef WINDOW_EXTRACT_ROW_MODE_EN
    logic [JW-1:0]                            j_q;
`endif
    logic signed [ORG_W-1:0]                  rowOrg_q;
    logic signed [ORG_W-1:0]                  colOrg_q;
    logic [WIN_H-1:0][WIN_W-1:0][CELL_W-1:0]  frame_q;
    logic                                     oob_q;
    logic [CNT_W-1:0]                         occ_q;
    logic                                     busy_q;
    logic                                     done_q;

    logic [GRID_ROWS-1:0][GRID_COLS-1:0][CELL_W-1:0] gridView;
    logic signed [ORG_W:0]                    rowSum;
    logic signed [ORG_W:0]                    colSum;
    logic                                     rowIn;
    logic [WIN_W-1:0][CELL_W-1:0]             rowCells;
    logic [WIN_W-1:0]                         rowOut;
    logic [WIN_W-1:0]                         rowHit;
    logic                                     stepOob;
    logic [CNT_W-1:0]                         stepCnt;
    logic                                     lastStep;
    logic                                     oob_d;
    logic [CNT_W-1:0]                         occ_d;

    assign gridView = c_grid;

    // Fetch every cell of the current window row; the sums are one bit wider than the origin
    // so a negative origin plus an index never wraps into a valid grid coordinate.
    always_comb begin
        rowSum   = (ORG_W+1)'(rowOrg_q) + (ORG_W+1)'(i_q);
        rowIn    = !rowSum[ORG_W] && (rowSum < ROWS_S);
        colSum   = '0;
        rowCells = '0;
        rowOut   = '0;
        rowHit   = '0;
        for (int jj = 0; jj < WIN_W; jj++) begin
            colSum = (ORG_W+1)'(colOrg_q) + (ORG_W+1)'(jj);
            if (rowIn && !colSum[ORG_W] && (colSum < COLS_S)) begin
                rowCells[jj] = gridView[rowSum[RW-1:0]][colSum[CIW-1:0]];
                rowHit[jj]   = (rowCells[jj] != '0);
            end else begin
                rowCells[jj] = FILL_VAL;
                rowOut[jj]   = 1'b1;
            end
        end
    end

    always_comb begin
        stepCnt = '0;
`ifdef WINDOW_EXTRACT_ROW_MODE_EN
        stepOob = |rowOut;
        for (int jj = 0; jj < WIN_W; jj++) begin
            stepCnt = stepCnt + CNT_W'(rowHit[jj]);
        end
        lastStep = (i_q == IW'(WIN_H - 1));
`else
        stepOob  = rowOut[j_q];
        stepCnt  = CNT_W'(rowHit[j_q]);
        lastStep = (i_q == IW'(WIN_H - 1)) && (j_q == JW'(WIN_W - 1));
`endif
        oob_d = oob_q | stepOob;
        occ_d = occ_q + stepCnt;
    end

    // IDLE and DONE both accept a request, which gives back-to-back scans through DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
`ifndef WINDOW_EXTRACT_ROW_MODE_EN
            j_q      <= '0;
`endif
            rowOrg_q <= '0;
            colOrg_q <= '0;
            frame_q  <= '0;
            oob_q    <= 1'b0;
            occ_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SCAN: begin
`ifdef WINDOW_EXTRACT_ROW_MODE_EN
                    frame_q[i_q] <= rowCells;
                    i_q          <= i_q + IW'(1);
`else
                    frame_q[i_q][j_q] <= rowCells[j_q];
                    if (j_q == JW'(WIN_W - 1)) begin
                        j_q <= '0;
                        i_q <= i_q + IW'(1);
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
`endif
                    oob_q <= oob_d;
                    occ_q <= occ_d;
                    if (lastStep) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        i_q     <= '0;
`ifndef WINDOW_EXTRACT_ROW_MODE_EN
                        j_q     <= '0;
`endif
                    end
                end
                default: begin
                    if (start) begin
                        state_q  <= SCAN;
                        busy_q   <= 1'b1;
                        rowOrg_q <= row_org;
                        colOrg_q <= col_org;
                        oob_q    <= 1'b0;
                        occ_q    <= '0;
                        i_q      <= '0;
`ifndef WINDOW_EXTRACT_ROW_MODE_EN
                        j_q      <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign c_frame = frame_q;
    assign oob     = oob_q;
    assign occ_cnt = occ_q;

endmodule
